// File: rtl/fifo_uart_tx_if.sv
// Read side of the single-clock FIFO as seen by the UART transmitter.
// master = consumer (drives the read strobe), slave = FIFO.
interface fifo_rd_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmit stage: pulls one word per frame from the FIFO and
// serialises it as start, LSB-first data, optional even parity, stop.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tx_enable,
  fifo_rd_if.master fifo,
  output logic      tx,
  output logic      busy,
  output logic      frame_done
);
  localparam int BW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_baud;
  logic [CW-1:0]         r_bit;
  logic                  r_par;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_rd_en;
  logic                  r_done;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_shift_nx;

  assign w_last     = (r_baud == BAUD_LAST);
  assign w_shift_nx = r_shift >> 1;

  assign tx              = r_tx;
  assign busy            = r_busy;
  assign frame_done      = r_done;
  assign fifo.fifo_rd_en = r_rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (tx_enable && !fifo.fifo_empty) begin
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        // FIFO registers its read data on this edge
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_shift <= fifo.fifo_data;
          r_par   <= ^fifo.fifo_data;
          r_tx    <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_last) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_baud  <= '0;
            r_shift <= w_shift_nx;
            r_bit   <= r_bit + 1'b1;
            if (r_bit != BIT_LAST) begin
              r_tx <= w_shift_nx[0];
            end else if (PARITY_EN != 0) begin
              r_tx    <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_last) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_last) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // registered, so raise one cycle ahead of the last one
            r_done <= (r_baud == BAUD_PRE);
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, per-cycle frame reference,
// table vectors, hand-written corner sequences and random drains.
module tb_fifo_uart_tx;
  localparam int C = 16;

  typedef struct {
    int         k;
    logic [7:0] d;
    int         len;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_en = 1'b0;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_rd_if #(.DATA_WIDTH(8)) f0 ();
  fifo_rd_if #(.DATA_WIDTH(8)) f1 ();

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0)
  ) u0 (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo(f0),
    .tx(tx0), .busy(busy0), .frame_done(done0)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1)
  ) u1 (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo(f1),
    .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  always #5 clk = ~clk;

  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int wp0 = 0, rp0 = 0, rd0 = 0, uf0 = 0;
  int wp1 = 0, rp1 = 0, rd1 = 0, uf1 = 0;

  assign f0.fifo_empty = (wp0 == rp0);
  assign f1.fifo_empty = (wp1 == rp1);

  always @(posedge clk) begin
    if (f0.fifo_rd_en) begin
      rd0 <= rd0 + 1;
      if (wp0 != rp0) begin
        f0.fifo_data <= mem0[rp0 % 64];
        rp0 <= rp0 + 1;
      end else begin
        uf0 <= uf0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (f1.fifo_rd_en) begin
      rd1 <= rd1 + 1;
      if (wp1 != rp1) begin
        f1.fifo_data <= mem1[rp1 % 64];
        rp1 <= rp1 + 1;
      end else begin
        uf1 <= uf1 + 1;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b);
    if (k == 0) begin
      mem0[wp0 % 64] = b;
      wp0 = wp0 + 1;
    end else begin
      mem1[wp1 % 64] = b;
      wp1 = wp1 + 1;
    end
  endtask

  function automatic logic g_tx(input int k);
    return (k != 0) ? tx1 : tx0;
  endfunction

  function automatic logic g_busy(input int k);
    return (k != 0) ? busy1 : busy0;
  endfunction

  function automatic logic g_done(input int k);
    return (k != 0) ? done1 : done0;
  endfunction

  function automatic logic g_rd(input int k);
    return (k != 0) ? f1.fifo_rd_en : f0.fifo_rd_en;
  endfunction

  // Expected line level in bit slot s of a frame carrying b.
  function automatic logic exp_bit(
    input int k, input logic [7:0] b, input int s
  );
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (k != 0 && s == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_frame(
    input  int         k,
    input  logic [7:0] b,
    output int         waited,
    output int         len,
    output logic [7:0] got,
    output logic       gpar
  );
    int bad, fdn, fdp, s;
    waited = 0;
    len = 0;
    got = '0;
    gpar = 1'b0;
    bad = 0;
    fdn = 0;
    fdp = -1;
    while (!g_rd(k) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!g_rd(k)) begin
      chk("rd_en timeout", 0, 1);
      return;
    end
    chk("busy at fetch", int'(g_busy(k)), 1);
    @(negedge clk);
    chk("rd_en one cycle", int'(g_rd(k)), 0);
    chk("tx idle in fetch", int'(g_tx(k)), 1);
    while (len < 400) begin
      @(negedge clk);
      if (!g_busy(k)) break;
      s = len / C;
      if (g_tx(k) !== exp_bit(k, b, s)) bad++;
      if (len % C == C / 2) begin
        if (s >= 1 && s <= 8) got[s-1] = g_tx(k);
        if (k != 0 && s == 9) gpar = g_tx(k);
      end
      if (g_done(k)) begin
        fdn++;
        fdp = len + 1;
      end
      len++;
    end
    chk("tx waveform", bad, 0);
    chk("frame_done count", fdn, 1);
    chk("frame_done position", fdp, len);
    chk("tx idle after", int'(g_tx(k)), 1);
    chk("done low after", int'(g_done(k)), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int w, l, r0, n, k, hi;
    logic [7:0] g, b;
    logic p;
    logic [7:0] q[$];

    tbl[0] = '{0, 8'hA5, 160, 1'b0};
    tbl[1] = '{1, 8'h07, 176, 1'b1};
    tbl[2] = '{1, 8'h03, 176, 1'b0};
    tbl[3] = '{0, 8'h00, 160, 1'b0};
    tbl[4] = '{0, 8'hFF, 160, 1'b0};
    tbl[5] = '{1, 8'h80, 176, 1'b1};
    tbl[6] = '{1, 8'hFF, 176, 1'b0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx0), 1);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done1), 0);
    rst = 1'b1;
    push(0, 8'h11);
    repeat (30) @(negedge clk);
    chk("disabled tx", int'(tx0), 1);
    chk("disabled busy", int'(busy0), 0);
    chk("disabled reads", rd0 + rd1, 0);
    wp0 = rp0;

    tx_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].k, tbl[i].d);
      run_frame(tbl[i].k, tbl[i].d, w, l, g, p);
      chk("table len", l, tbl[i].len);
      chk("table data", int'(g), int'(tbl[i].d));
      if (tbl[i].k != 0) chk("table parity", int'(p), int'(tbl[i].par));
    end
    chk("table reads", rd0 + rd1, 7);

    r0 = rd0;
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    for (int i = 1; i <= 3; i++) begin
      run_frame(0, 8'(i), w, l, g, p);
      chk("drain data", int'(g), i);
      if (i > 1) chk("drain gap", w + 2, 3);
    end
    repeat (40) @(negedge clk);
    chk("drain reads", rd0 - r0, 3);
    chk("drain idle busy", int'(busy0), 0);

    r0 = rd0;
    push(0, 8'h5A);
    push(0, 8'hC3);
    fork
      begin
        repeat (70) @(negedge clk);
        tx_en = 1'b0;
      end
    join_none
    run_frame(0, 8'h5A, w, l, g, p);
    chk("gated frame1 data", int'(g), 8'h5A);
    repeat (50) @(negedge clk);
    chk("gated reads", rd0 - r0, 1);
    chk("gated busy", int'(busy0), 0);
    tx_en = 1'b1;
    run_frame(0, 8'hC3, w, l, g, p);
    chk("gated frame2 data", int'(g), 8'hC3);
    chk("gated reads after", rd0 - r0, 2);

    push(0, 8'hFF);
    n = 0;
    while (!f0.fifo_rd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2 + C + 4 * C + 5) @(negedge clk);
    chk("busy before reset", int'(busy0), 1);
    rst = 1'b0;
    #1;
    chk("async reset tx", int'(tx0), 1);
    chk("async reset busy", int'(busy0), 0);
    chk("async reset rd_en", int'(f0.fifo_rd_en), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy0) hi++;
    end
    chk("no frame after reset", hi, 0);
    push(0, 8'h3C);
    run_frame(0, 8'h3C, w, l, g, p);
    chk("post-reset data", int'(g), 8'h3C);

    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        q.push_back(b);
        push(k, b);
      end
      for (int j = 0; j < n; j++) begin
        b = q.pop_front();
        run_frame(k, b, w, l, g, p);
        chk("rand data", int'(g), int'(b));
        chk("rand len", l, (10 + k) * C);
        if (k != 0) chk("rand parity", int'(p), $countones(b) % 2);
        if (j > 0) chk("rand gap", w + 2, 3);
      end
    end

    repeat (10) @(negedge clk);
    chk("underflow reads", uf0 + uf1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
